// File: rtl/truth_table_checker_pkg.sv
// Shared types and helpers for the truth-table self-test engine.
package truth_table_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2, never less than one bit so a counter always exists.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Settle timer: emits a one-cycle tick after SETTLE cycles, restarting each tick.
module tt_settle_timer
  import truth_table_checker_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = !clear && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive sweep of an N_IN-input combinational unit; captures its truth table
// and compares it against a latched expected mask.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   exp_tt,
  output logic [N_IN-1:0]      vec_out,
  input  logic                 resp_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   tt_out,
  output logic                 fail_valid,
  output logic [N_IN-1:0]      fail_idx
);

  localparam int TT_W = 2**N_IN;
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic              fail_valid_q, fail_valid_d;
  logic [N_IN-1:0]   fail_idx_q, fail_idx_d;
  logic [TT_W-1:0]   exp_q, exp_d;
  logic              tick;

  // The timer only runs in RUN; every other state holds it at zero so the
  // first vector of a sweep gets its full settle time.
  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q != ST_RUN),
    .tick  (tick)
  );

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    tt_d         = tt_q;
    fail_valid_d = fail_valid_q;
    fail_idx_d   = fail_idx_q;
    exp_d        = exp_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_RUN;
          busy_d       = 1'b1;
          vec_d        = '0;
          exp_d        = exp_tt;
          tt_d         = '0;
          pass_d       = 1'b0;
          fail_valid_d = 1'b0;
          fail_idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (tick) begin
          tt_d[vec_q] = resp_in;
          // Only the lowest failing index is kept.
          if ((resp_in != exp_q[vec_q]) && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_idx_d   = vec_q;
          end
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (tt_d == exp_q);
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      tt_q         <= '0;
      fail_valid_q <= 1'b0;
      fail_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      tt_q         <= tt_d;
      fail_valid_q <= fail_valid_d;
      fail_idx_q   <= fail_idx_d;
    end
  end

  // Expected mask is pure data and is only meaningful after an accepted start.
  always_ff @(posedge clk) begin
    exp_q <= exp_d;
  end

  assign vec_out    = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign tt_out     = tt_q;
  assign fail_valid = fail_valid_q;
  assign fail_idx   = fail_idx_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: 3-input majority function as the unit under check.
module tb_truth_table_checker;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] exp_tt;
  logic [2:0] vec_out;
  logic       resp_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] tt_out;
  logic       fail_valid;
  logic [2:0] fail_idx;

  int vectors;
  int miscompares;

  truth_table_checker #(
    .N_IN   (3),
    .SETTLE (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .exp_tt     (exp_tt),
    .vec_out    (vec_out),
    .resp_in    (resp_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .tt_out     (tt_out),
    .fail_valid (fail_valid),
    .fail_idx   (fail_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Majority of three.
  always_comb begin
    resp_in = (vec_out[0] & vec_out[1]) | (vec_out[0] & vec_out[2]) | (vec_out[1] & vec_out[2]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vec"},   32'(vec_out),    32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_pass"},  32'(pass),       32'd0);
    chk({tag, "_tt"},    32'(tt_out),     32'd0);
    chk({tag, "_fv"},    32'(fail_valid), 32'd0);
    chk({tag, "_fidx"},  32'(fail_idx),   32'd0);
  endtask

  // Called at a falling edge; start is raised so the next rising edge is E0.
  task automatic run_sweep(input string tag, input logic [7:0] exp, input logic [7:0] want_tt,
                           input logic want_pass, input logic want_fv, input logic [2:0] want_idx,
                           input bit poke, input bit chain);
    start  = 1'b1;
    exp_tt = exp;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_acc_busy"}, 32'(busy),       32'd1);
    chk({tag, "_acc_tt"},   32'(tt_out),     32'd0);
    chk({tag, "_acc_pass"}, 32'(pass),       32'd0);
    chk({tag, "_acc_fv"},   32'(fail_valid), 32'd0);
    for (int k = 0; k < 16; k++) begin
      chk({tag, "_vec"},  32'(vec_out), 32'(k / 2));
      chk({tag, "_busy"}, 32'(busy),    32'd1);
      chk({tag, "_done"}, 32'(done),    32'd0);
      if (poke && k == 4) start = 1'b1;
      if (poke && k == 5) start = 1'b0;
      if (poke && k == 6) exp_tt = 8'h00;
      @(negedge clk);
    end
    chk({tag, "_done_pulse"}, 32'(done),       32'd1);
    chk({tag, "_done_busy"},  32'(busy),       32'd0);
    chk({tag, "_done_vec"},   32'(vec_out),    32'd7);
    chk({tag, "_tt"},         32'(tt_out),     32'(want_tt));
    chk({tag, "_pass"},       32'(pass),       32'(want_pass));
    chk({tag, "_fv"},         32'(fail_valid), 32'(want_fv));
    chk({tag, "_fidx"},       32'(fail_idx),   32'(want_idx));
    if (chain) begin
      start  = 1'b1;
      exp_tt = 8'hE8;
    end
    @(negedge clk);
    chk({tag, "_after_done"}, 32'(done),    32'd0);
    chk({tag, "_after_busy"}, 32'(busy),    32'd0);
    chk({tag, "_hold_tt"},    32'(tt_out),  32'(want_tt));
    chk({tag, "_hold_pass"},  32'(pass),    32'(want_pass));
    chk({tag, "_hold_vec"},   32'(vec_out), 32'd7);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    start  = 1'b0;
    exp_tt = 8'h00;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("idle");

    run_sweep("maj_ok", 8'hE8, 8'hE8, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    run_sweep("exp_e9", 8'hE9, 8'hE8, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    run_sweep("exp_68", 8'h68, 8'hE8, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
    run_sweep("exp_00", 8'h00, 8'hE8, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    run_sweep("ignored", 8'hE8, 8'hE8, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);

    // Reset while idle wipes held results.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("idle_rst");
    rst = 1'b0;
    @(negedge clk);

    // Mid-sweep reset at E0+7.
    start  = 1'b1;
    exp_tt = 8'hE8;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_rst");
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("mid_rst_no_done", 32'(done), 32'd0);
      chk("mid_rst_no_busy", 32'(busy), 32'd0);
    end
    run_sweep("post_rst", 8'hE8, 8'hE8, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // Start held through DONE is ignored there, then accepted from IDLE.
    run_sweep("b2b_a", 8'hE9, 8'hE8, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    run_sweep("b2b_b", 8'hE8, 8'hE8, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Synthesizable self-test engine that exercises an N-input combinational block.
- Sweeps every input vector, waits a settle time for each, samples the single-bit response and assembles the captured truth table.
- Compares the captured table with an expected mask and reports pass/fail plus the first failing index.
- Sits between a control/status source (switches, LEDs or a bench) and the combinational unit under check. It is the in-hardware response side of exhaustive stimulus.

Parameters:
- N_IN, 3, number of DUT inputs; table width TT_W = 2**N_IN.
- SETTLE, 2, clock cycles each vector is held before its response is sampled; legal values are >= 1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  begins a sweep; honoured only in IDLE
- exp_tt  input  TT_W  expected truth table, bit v = expected response for vector v; latched on an accepted start
- vec_out  output  N_IN  input vector driven to the unit under check
- resp_in  input  1  response of the unit under check
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when a sweep completes
- pass  output  1  captured table equals latched exp_tt; valid from done, held until next start
- tt_out  output  TT_W  captured truth table, bit v = resp_in sampled for vector v
- fail_valid  output  1  at least one mismatch was recorded
- fail_idx  output  N_IN  lowest vector index that mismatched

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high: clk and rst, rst sampled on the rising edge of clk.
- Reset values: vec_out=0, busy=0, done=0, pass=0, tt_out=0, fail_valid=0, fail_idx=0, state=IDLE, settle counter=0.
- Reset mid-sweep: returns to those values at the next edge; the sweep is abandoned and no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - go to RUN; busy=1; vec_out=0; settle counter=0
  - latch exp_tt into an internal register
  - clear tt_out, pass, fail_valid and fail_idx to 0
- RUN:
  - vec_out holds value v for exactly SETTLE cycles, from edge E0+v*SETTLE to edge E0+(v+1)*SETTLE.
  - At edge E0+(v+1)*SETTLE: tt_out[v] <= resp_in.
  - If resp_in != latched exp[v] and fail_valid=0: set fail_valid=1 and fail_idx=v. Later mismatches do not overwrite fail_idx.
  - Then, if v < TT_W-1: vec_out <= v+1 and the settle counter resets.
  - If v = TT_W-1: go to DONE; busy=0; done=1; pass <= (final table == latched exp). The final table includes the bit sampled on this edge.
  - vec_out stays at TT_W-1 through DONE; it returns to 0 only on the next accepted start or on reset.
- DONE:
  - lasts exactly one cycle, then IDLE; done returns to 0.
  - start during DONE is ignored.
- Latency: done is high in the cycle after edge E0 + TT_W*SETTLE. For N_IN=3 and SETTLE=2 that edge is E0+16.
- start while busy or in DONE: ignored; no restart, no effect on latched exp.
- exp_tt changes after E0: no effect on the current sweep.
- Results (tt_out, pass, fail_valid, fail_idx) hold in IDLE until the next accepted start or reset.
- Width rules:
  - settle counter is clog2(SETTLE+1) bits; it compares to SETTLE-1.
  - vec_out counter is N_IN bits; it never wraps inside a sweep because the terminal test is on v = TT_W-1.
- pass and fail_valid are consistent at done: pass=1 exactly when fail_valid=0.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_RUN, ST_DONE) and a clog2 function for counter widths.
- One sub-module is natural: tt_settle_timer. Inputs: clk, rst, clear. Output: a single-cycle tick every SETTLE cycles. The FSM uses tick as its sample strobe.

Test Plan:
- Reset: hold rst=1 for 2 cycles mid-idle -> all outputs 0, busy=0, done never pulses.
- Majority DUT, correct case: resp_in=maj(vec_out), exp_tt=8'hE8, SETTLE=2, start at E0 -> vec_out steps 0..7, each held 2 cycles. done pulses exactly once, in the cycle after E0+16. tt_out=8'hE8, pass=1, fail_valid=0.
- Mismatch reporting, same DUT:
  - exp_tt=8'hE9 -> pass=0, fail_valid=1, fail_idx=0, tt_out=8'hE8.
  - exp_tt=8'h68 -> fail_idx=7.
  - exp_tt=8'h00 -> fail_idx=3, the first of several mismatches.
- Ignored inputs: pulse start at E0+5 and change exp_tt to 8'h00 at E0+6 -> done still in the cycle after E0+16, pass=1 against the latched 8'hE8.
- Mid-sweep reset: assert rst at E0+7 -> next edge all outputs 0, busy=0, no done pulse. A new start afterwards completes normally with pass=1.
- Back-to-back starts: start high during the DONE cycle -> ignored, state goes to IDLE. start the next cycle -> accepted, tt_out cleared to 0 at the accepting edge, sweep repeats with identical timing.
